// File: rtl/clk_div_sched.sv
// clk_div_sched: run-time controller for a divided clock output.
// Owns the half-period ratio, takes new ratios over a valid/ready handshake,
// and only changes ratio or stops on full-period (falling) boundaries so the
// divided output never produces a runt pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           run request (sampled at falling boundaries while running)
//   cfg_valid    new half-period offered
//   cfg_half     offered half-period in clk cycles (0 is rejected)
//   cfg_ready    ratio can be accepted this cycle
//   cfg_err      one-cycle pulse after a zero half-period was accepted
//   div_out      divided clock, period 2*half_active, 50% duty
//   tick         one-cycle pulse in the first high cycle of div_out
//   busy         controller is not idle
//   half_active  half-period currently in use
module clk_div_sched #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] half_active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic accept;
  logic legal;
  logic boundary;
  logic fall;

  assign accept   = cfg_valid & ready_q;
  assign legal    = accept & (cfg_half != '0);
  assign boundary = (cnt_q == (half_q - CNT_W'(1)));
  assign fall     = boundary & div_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      half_q  <= CNT_W'(DEFAULT_HALF);
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      half_q  <= half_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter, ratio and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    half_d  = half_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    err_d   = accept & ~legal;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        div_d = 1'b0;
        // A ratio accepted alongside the start governs the first period.
        if (legal) half_d = cfg_half;
        if (en) state_d = RUN;
      end

      RUN, PEND: begin
        if (boundary) begin
          cnt_d  = '0;
          div_d  = ~div_q;
          tick_d = ~div_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        // New ratio is parked; never applied at the accept edge itself.
        if (state_q == RUN && legal) begin
          pend_d  = cfg_half;
          state_d = PEND;
        end

        if (fall) begin
          if (state_q == PEND) begin
            half_d  = pend_q;
            state_d = RUN;
          end
          if (!en) begin
            // Stopping on the same edge a ratio is accepted: keep the ratio
            // for the next start rather than dropping it.
            if (state_q == RUN && legal) half_d = cfg_half;
            div_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_d = (state_d != PEND);
  assign busy_d  = (state_d != IDLE);

  assign cfg_ready   = ready_q;
  assign cfg_err     = err_q;
  assign div_out     = div_q;
  assign tick        = tick_q;
  assign busy        = busy_q;
  assign half_active = half_q;

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Run-time controller for the team's divided-clock generation. It owns the divide ratio, accepts new ratios through a valid/ready handshake and starts and stops the divided output. Ratio changes and stops take effect only on full-period boundaries, so downstream logic clocked or enabled from the output never sees a runt pulse. It also produces a one-cycle tick per output period for enable-style use.

Parameters:
CNT_W, 32, width of the half-period counter and ratio registers
DEFAULT_HALF, 4, half-period (in clk cycles) loaded at reset; must be >= 1

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_half  input  CNT_W  offered half-period in clk cycles; 0 is illegal
cfg_ready  output  1  controller can accept a ratio this cycle
cfg_err  output  1  one-cycle pulse: an accepted offer had cfg_half == 0
div_out  output  1  divided clock, period = 2*half_active clk cycles, 50% duty
tick  output  1  one-cycle pulse in the cycle div_out first reads 1
busy  output  1  state != IDLE
half_active  output  CNT_W  ratio currently in use

Behaviour:
- Reset is asynchronous. While rst_n = 0:
  - state = IDLE; counter = 0; pending = 0.
  - div_out = 0, tick = 0, cfg_err = 0, busy = 0, cfg_ready = 1.
  - half_active = DEFAULT_HALF.
- Reset asserted mid-operation aborts everything immediately, including any pending ratio.
- All outputs are registered.
- States: IDLE, RUN, PEND.
- Handshake: an offer is accepted when cfg_valid & cfg_ready are both 1 at a clock edge.
  - cfg_ready = 1 in IDLE and RUN; cfg_ready = 0 in PEND.
  - If the accepted cfg_half == 0: cfg_err = 1 for the next cycle; no state or ratio change.
- IDLE:
  - counter held at 0; div_out = 0.
  - A legal accept loads half_active on the next edge.
  - en = 1 at an edge moves to RUN. If a legal accept occurs in the same cycle as the start, the new ratio governs the first period.
- RUN:
  - counter increments every cycle.
  - Boundary: when counter == half_active-1, counter is set to 0 and div_out toggles.
  - A 0->1 toggle sets tick = 1 in the same cycle div_out becomes 1; otherwise tick = 0.
  - half_active = 1 toggles div_out every cycle.
  - A legal accept stores cfg_half in pending and moves to PEND. This holds even if the accept cycle is itself a boundary; the new ratio is not applied at that boundary.
- PEND:
  - Counts and toggles exactly as RUN, using the old ratio.
  - At the next 1->0 boundary (end of a full period): half_active <= pending, counter <= 0, return to RUN, cfg_ready = 1 next cycle.
  - The next period uses the new ratio.
- Stop:
  - en is sampled only at 1->0 boundaries in RUN or PEND.
  - en = 0 there: div_out falls to 0, move to IDLE, counter = 0.
  - If stopping from PEND, pending is applied to half_active on that same edge.
  - If en is dropped and re-raised between boundaries, there is no effect.
  - A stop requested during the low half completes that low half plus one full high half before stopping.
- Counter width is CNT_W. No overflow is possible, since counter < half_active <= 2^CNT_W-1.

Test Plan:
- Reset, DEFAULT_HALF=4, en=1 at cycle 0 -> div_out 0 for 4 cycles, 1 for 4, period 8; tick high exactly once per 8 cycles, coincident with the first div_out=1 cycle.
- In IDLE offer cfg_half=3, then en=1 -> half_active=3 next cycle; div_out period 6; busy=1 from the first RUN cycle.
- Running at 4, offer cfg_half=2 during the high phase -> cfg_ready=0 until the falling boundary; current high phase lasts 4; thereafter period 4; half_active switches on the falling edge.
- Offer cfg_half=0 in RUN -> cfg_err pulses 1 cycle; half_active unchanged; period unchanged; state stays RUN.
- Drop en two cycles into the low phase (half=4) -> 2 more low + 4 high cycles, then div_out=0, busy=0; no high pulse shorter than 4.
- Assert rst_n=0 mid-high-phase while PEND holds 7 -> div_out=0 immediately (asynchronous); after release half_active=4, cfg_ready=1, state IDLE.
